data_ram_sync: RTL and testbench

DATA_RAM_SYNC -- requirements
Module: data_ram_sync

---
 rtl/data_ram_sync.sv | 109 ++++++++++
 tb/tb_data_ram_sync.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_sync.sv
// data_ram_sync: big-endian byte RAM with programmable wait states and two-beat doublewords.
// Define DATA_RAM_SIGNED_LOAD_EN to add the signed_ld port for sign-extending sub-word loads.
module data_ram_sync #(
  parameter int ADDR_BITS = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mfa,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
`ifdef DATA_RAM_SIGNED_LOAD_EN
  input  logic        signed_ld,
`endif
  output logic [31:0] data_out,
  output logic        moc,
  output logic        align_err
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WLOAD = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, BEAT2_WAIT, BEAT2_ACCESS} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [3:0] cnt, cnt_n;
  logic op_rw;
  logic [1:0] op_size;
  logic [ADDR_BITS-1:0] op_addr, a, a1, a2, a3;
  logic accept, access, misaligned, sx;
  logic [31:0] rdata;
  logic unused_addr;
  assign unused_addr = ^addr;
  // moc gates acceptance so a new request starts no earlier than the cycle after completion
  assign accept = state == IDLE && mfa && !moc;
  assign access = state == ACCESS || state == BEAT2_ACCESS;
  assign misaligned = (op_size == 2'b01 && op_addr[0]) || (op_size[1] && op_addr[1:0] != 2'b00);
  assign a = state == BEAT2_ACCESS ? op_addr + ADDR_BITS'(4) : op_addr;
  assign a1 = a + ADDR_BITS'(1);
  assign a2 = a + ADDR_BITS'(2);
  assign a3 = a + ADDR_BITS'(3);
`ifdef DATA_RAM_SIGNED_LOAD_EN
  logic op_sgn;
  always_ff @(posedge clk)
    if (reset) op_sgn <= 1'b0;
    else if (accept) op_sgn <= signed_ld;
  assign sx = op_sgn;
`else
  assign sx = 1'b0;
`endif
  always_comb
    rdata = op_size == 2'b00 ? {{24{sx & mem[a][7]}}, mem[a]}
          : op_size == 2'b01 ? {{16{sx & mem[a][7]}}, mem[a], mem[a1]}
          : {mem[a], mem[a1], mem[a2], mem[a3]};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        cnt_n = WLOAD;
        if (accept) state_n = WAIT_STATES > 0 ? WAIT : ACCESS;
      end
      WAIT, BEAT2_WAIT:
        if (cnt == 4'd0) state_n = state == WAIT ? ACCESS : BEAT2_ACCESS;
        else cnt_n = cnt - 4'd1;
      ACCESS: begin
        cnt_n = WLOAD;
        state_n = op_size == 2'b11 && !misaligned ? (WAIT_STATES > 0 ? BEAT2_WAIT : BEAT2_ACCESS) : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_out <= 32'd0;
      moc <= 1'b0;
      align_err <= 1'b0;
      op_rw <= 1'b0;
      op_size <= 2'b00;
      op_addr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      moc <= access;
      align_err <= access && misaligned;
      if (accept) begin
        op_rw <= rw;
        op_size <= size;
        op_addr <= addr[ADDR_BITS-1:0];
      end
      if (access && misaligned) data_out <= 32'd0;
      else if (access && !op_rw) data_out <= rdata;
    end
  // Memory is never cleared; a write on a reset edge is dropped
  always_ff @(posedge clk)
    if (!reset && access && op_rw && !misaligned)
      if (op_size == 2'b00) mem[a] <= data_in[7:0];
      else if (op_size == 2'b01) begin
        mem[a] <= data_in[15:8];
        mem[a1] <= data_in[7:0];
      end else begin
        mem[a] <= data_in[31:24];
        mem[a1] <= data_in[23:16];
        mem[a2] <= data_in[15:8];
        mem[a3] <= data_in[7:0];
      end
endmodule

// File: tb/tb_data_ram_sync.sv
// tb_data_ram_sync: vector table, reset corner cases and random ops against a byte-array model.
module tb_data_ram_sync;
  localparam int WS = 2;
`ifdef DATA_RAM_SIGNED_LOAD_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, mfa = 1'b0, rw = 1'b0, signed_ld = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = 32'd0, data_in = 32'd0;
  logic [31:0] data_out;
  logic moc, align_err;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] ref_mem [256];
  logic [31:0] last_dout = 32'd0;

  always #5 clk = ~clk;

  data_ram_sync #(.ADDR_BITS(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .mfa(mfa), .rw(rw), .size(size), .addr(addr), .data_in(data_in),
`ifdef DATA_RAM_SIGNED_LOAD_EN
    .signed_ld(signed_ld),
`endif
    .data_out(data_out), .moc(moc), .align_err(align_err));

  typedef struct {
    logic r; logic [1:0] s; logic [31:0] a, d1, d2; logic sg;
    logic [31:0] x1, x2; logic xe;
  } vec_t;
  vec_t tv[22];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain byte array, big-endian assembly, one entry per beat
  task automatic model(input logic r, input logic [1:0] s, input logic [31:0] ad, d1, d2, input logic sg,
                       output logic [31:0] x1, x2, output logic xe, output int xn);
    int a, nb, base;
    logic [31:0] v;
    a = int'(ad % 256);
    nb = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    xe = (s == 2'd1 && a % 2 != 0) || (s >= 2'd2 && a % 4 != 0);
    xn = (s == 2'd3 && !xe) ? 2 : 1;
    x1 = 'x;
    x2 = 'x;
    for (int b = 0; b < xn; b++) begin
      base = (a + 4 * b) % 256;
      if (xe) last_dout = 32'd0;
      else if (r) begin
        for (int i = 0; i < nb; i++) ref_mem[(base + i) % 256] = 8'(((b != 0) ? d2 : d1) >> (8 * (nb - 1 - i)));
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[(base + i) % 256]);
        if (SGN && sg && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFFFFFF << (8 * nb));
        last_dout = v;
      end
      if (b == 0) x1 = last_dout;
      else x2 = last_dout;
    end
  endtask

  // Drive one request from a negedge, then watch a fixed window scrambling the request lines
  task automatic op(input logic r, input logic [1:0] s, input logic [31:0] ad, d1, d2, input logic sg,
                    output logic [31:0] q1, q2, output logic e1, e2, output int l1, l2, nm);
    int last;
    mfa = 1'b1; rw = r; size = s; addr = ad; data_in = d1; signed_ld = sg;
    @(posedge clk); #1;
    mfa = 1'b0;
    q1 = 'x; q2 = 'x; e1 = 'x; e2 = 'x; l1 = -1; l2 = -1; nm = 0; last = 0;
    for (int n = 1; n <= 2 * WS + 5; n++) begin
      @(negedge clk);
      rw = 1'($urandom); size = 2'($urandom); addr = $urandom;
      if (moc) begin
        if (nm == 0) begin q1 = data_out; e1 = align_err; l1 = n - 1; data_in = d2; end
        else if (nm == 1) begin q2 = data_out; e2 = align_err; l2 = n - last; end
        last = n;
        nm++;
      end
    end
  endtask

  task automatic run(input string nm, input logic r, input logic [1:0] s, input logic [31:0] ad, d1, d2,
                     input logic sg, output logic [31:0] q1, q2, output logic e1);
    logic [31:0] x1, x2;
    logic xe, e2;
    int xn, l1, l2, gn;
    model(r, s, ad, d1, d2, sg, x1, x2, xe, xn);
    op(r, s, ad, d1, d2, sg, q1, q2, e1, e2, l1, l2, gn);
    chk({nm, " moc count"}, 32'(gn), 32'(xn));
    chk({nm, " data1"}, q1, x1);
    chk({nm, " err1"}, 32'(e1), 32'(xe));
    chk({nm, " latency1"}, 32'(l1), 32'(WS + 1));
    if (xn == 2) begin
      chk({nm, " data2"}, q2, x2);
      chk({nm, " err2"}, 32'(e2), 32'd0);
      chk({nm, " latency2"}, 32'(l2), 32'(WS + 1));
    end
  endtask

  // Reset k negedges after accept of a byte write; k = WS+1 lands on the ACCESS edge
  task automatic rst_mid(input string nm, input int k, input logic [31:0] ad);
    int seen;
    seen = 0;
    mfa = 1'b1; rw = 1'b1; size = 2'b00; addr = ad; data_in = 32'h5A;
    @(posedge clk); #1;
    mfa = 1'b0;
    repeat (k) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    if (moc) seen++;
    reset = 1'b0;
    for (int n = 0; n < 2 * WS + 5; n++) begin
      @(negedge clk);
      if (moc) seen++;
    end
    chk({nm, " moc count"}, 32'(seen), 32'd0);
    chk({nm, " data_out"}, data_out, 32'd0);
    chk({nm, " align_err"}, 32'(align_err), 32'd0);
    last_dout = 32'd0;
  endtask

  initial begin
    logic [31:0] q1, q2, ad;
    logic e1, r, sg;
    logic [1:0] s;
    tv[0]  = '{1'b1, 2'd2, 32'h0,        32'h12345678, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tv[1]  = '{1'b0, 2'd2, 32'h0,        32'h0,        32'h0,        1'b0, 32'h12345678, 32'h0,        1'b0};
    tv[2]  = '{1'b1, 2'd0, 32'h1,        32'hFFFFFFB5, 32'h0,        1'b0, 32'h12345678, 32'h0,        1'b0};
    tv[3]  = '{1'b0, 2'd2, 32'h0,        32'h0,        32'h0,        1'b0, 32'h12B55678, 32'h0,        1'b0};
    tv[4]  = '{1'b1, 2'd3, 32'h8,        32'hAABBCCDD, 32'h11223344, 1'b0, 32'h12B55678, 32'h12B55678, 1'b0};
    tv[5]  = '{1'b0, 2'd3, 32'h8,        32'h0,        32'h0,        1'b0, 32'hAABBCCDD, 32'h11223344, 1'b0};
    tv[6]  = '{1'b1, 2'd1, 32'h3,        32'h0000FFFF, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    tv[7]  = '{1'b0, 2'd2, 32'h0,        32'h0,        32'h0,        1'b0, 32'h12B55678, 32'h0,        1'b0};
    tv[8]  = '{1'b0, 2'd2, 32'h4,        32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tv[9]  = '{1'b1, 2'd0, 32'h4,        32'h00000080, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tv[10] = '{1'b0, 2'd0, 32'h4,        32'h0,        32'h0,        1'b1, SGN ? 32'hFFFFFF80 : 32'h80, 32'h0, 1'b0};
    tv[11] = '{1'b0, 2'd0, 32'h4,        32'h0,        32'h0,        1'b0, 32'h00000080, 32'h0,        1'b0};
    tv[12] = '{1'b0, 2'd1, 32'h2,        32'h0,        32'h0,        1'b1, 32'h00005678, 32'h0,        1'b0};
    tv[13] = '{1'b0, 2'd1, 32'h8,        32'h0,        32'h0,        1'b1, SGN ? 32'hFFFFAABB : 32'hAABB, 32'h0, 1'b0};
    tv[14] = '{1'b0, 2'd2, 32'h4,        32'h0,        32'h0,        1'b1, 32'h80000000, 32'h0,        1'b0};
    tv[15] = '{1'b0, 2'd3, 32'hA,        32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    tv[16] = '{1'b1, 2'd2, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tv[17] = '{1'b0, 2'd2, 32'h1FC,      32'h0,        32'h0,        1'b0, 32'hCAFEF00D, 32'h0,        1'b0};
    tv[18] = '{1'b0, 2'd3, 32'hFC,       32'h0,        32'h0,        1'b0, 32'hCAFEF00D, 32'h12B55678, 1'b0};
    tv[19] = '{1'b0, 2'd0, 32'h3,        32'h0,        32'h0,        1'b1, 32'h00000078, 32'h0,        1'b0};
    tv[20] = '{1'b1, 2'd1, 32'hE,        32'h0000BEEF, 32'h0,        1'b0, 32'h00000078, 32'h0,        1'b0};
    tv[21] = '{1'b0, 2'd2, 32'hC,        32'h0,        32'h0,        1'b0, 32'h1122BEEF, 32'h0,        1'b0};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset data_out", data_out, 32'd0);
    chk("reset moc", 32'(moc), 32'd0);
    chk("reset align_err", 32'(align_err), 32'd0);
    for (int i = 0; i < 64; i++) run("preload", 1'b1, 2'd2, 32'(i * 4), 32'd0, 32'd0, 1'b0, q1, q2, e1);
    for (int i = 0; i < 22; i++) begin
      run($sformatf("vec%0d", i), tv[i].r, tv[i].s, tv[i].a, tv[i].d1, tv[i].d2, tv[i].sg, q1, q2, e1);
      chk($sformatf("vec%0d table data1", i), q1, tv[i].x1);
      chk($sformatf("vec%0d table err", i), 32'(e1), 32'(tv[i].xe));
      if (tv[i].s == 2'd3 && !tv[i].xe) chk($sformatf("vec%0d table data2", i), q2, tv[i].x2);
    end
    rst_mid("reset in wait", 1, 32'h20);
    run("after reset in wait", 1'b0, 2'd0, 32'h20, 32'd0, 32'd0, 1'b0, q1, q2, e1);
    rst_mid("reset on access", WS + 1, 32'h21);
    run("after reset on access", 1'b0, 2'd0, 32'h21, 32'd0, 32'd0, 1'b0, q1, q2, e1);
    for (int i = 0; i < 300; i++) begin
      r = 1'($urandom); s = 2'($urandom); sg = 1'($urandom); ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      run($sformatf("rand%0d", i), r, s, ad, $urandom, $urandom, sg, q1, q2, e1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
